countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter that complements the team's up-counting `counter` block. It accepts a start value through a valid/ready load handshake, decrements once per enabled cycle, and emits a one-cycle `done` pulse on reaching terminal count. It optionally reloads for periodic operation. It sits beside `counter` in the matrix datapath control and times fixed-length phases, such as row or column sweeps, for the sequencing logic.

## Interface
- COUNT_LEN, default 10. Counter width is COUNT_LEN+1 bits, the same width convention as `counter`.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- load_valid  input  1  a start value is offered.
- load_ready  output  1  block accepts a load; combinational, equals (state == IDLE).
- load_value  input  COUNT_LEN+1  start value N; unsigned.
- auto_reload  input  1  reload N at terminal count instead of stopping.
- enable  input  1  decrement permission; 0 pauses the count.
- abort  input  1  cancel a running countdown.
- count  output  COUNT_LEN+1  current remaining count, registered.
- busy  output  1  high in RUN, registered.
- done  output  1  one-cycle terminal-count pulse, registered.
- done_cnt  output  8  number of done pulses since reset; wraps 255 -> 0.

## Operation
- The FSM has two states, IDLE and RUN. There is an internal reload register `reload_reg` of width COUNT_LEN+1.
- Reset values: state IDLE, count 0, reload_reg 0, busy 0, done 0, done_cnt 0. load_ready is 1 in the first cycle after reset.
- Priority on each edge: reset > abort > load/decrement.
- done defaults to 0 every cycle. It is high only in the cycle following the edge that set it.
- IDLE, load accepted (load_valid & load_ready):
  - Capture load_value into count and into reload_reg.
  - If N != 0: go to RUN, busy <= 1.
  - If N == 0: stay in IDLE, count <= 0, done <= 1, done_cnt increments. This is a zero-length countdown, and auto_reload is ignored.
- IDLE, no load: count holds. An abort in IDLE has no effect.
- RUN, abort = 1:
  - count <= 0, state IDLE, busy <= 0.
  - No done pulse, and done_cnt is unchanged. enable is ignored.
- RUN, enable = 0: count, state and busy hold. A pause has no length limit.
- RUN, enable = 1, count > 1: count <= count - 1.
- RUN, enable = 1, count == 1 (terminal edge):
  - done <= 1, done_cnt <= done_cnt + 1.
  - If auto_reload = 1 (sampled at this edge): count <= reload_reg, stay in RUN. In this case count never displays 0.
  - Else: count <= 0, state IDLE, busy <= 0.
- load_valid during RUN is not accepted, because load_ready = 0. The offered value is ignored, and the source must hold it until load_ready returns.
- Arithmetic is unsigned, with no underflow path: a decrement never occurs at count 0, because RUN is never entered with count 0.
- done_cnt is 8-bit modulo arithmetic.

## Timing
- Load accepted at edge E0: count = N and busy = 1 after E0.
- With enable held high, count = N-k after edge Ek.
- done is high after edge EN, which is N cycles of latency from load acceptance to done.
- In non-reload mode, load_ready is 1 in the same cycle that done is 1. A new load offered then is accepted at the next edge, giving back-to-back countdowns with zero idle cycles.
- In auto-reload mode with constant enable, done pulses every N cycles, and count cycles N, N-1, ..., 1, N, ...
- Each enable-low cycle extends latency by exactly 1 cycle.
- Reset asserted mid-countdown: all outputs return to reset values after that edge. No done pulse is produced, even if count == 1 and enable == 1 at the same edge.
- abort and the terminal condition on the same edge: abort wins, so there is no done pulse.

## Test plan
- Reset, then load N=5 with enable=1 constantly: count reads 5,4,3,2,1,0 on consecutive cycles; done is high exactly in the cycle count=0 (5 cycles after the load edge); busy falls with it; done_cnt = 1.
- Load N=4 with auto_reload=1 and enable=1 for 12 cycles: done pulses at cycles 4, 8 and 12; count sequence is 4,3,2,1,4,3,2,1,...; busy stays 1; done_cnt = 3.
- Load N=6, then drop enable for 3 cycles while count=3: count holds at 3; done arrives at cycle 9 instead of 6.
- Load N=7, then assert abort while count=2: count goes to 0, busy to 0, with no done pulse and done_cnt unchanged. load_valid with N=0 then gives done one cycle after acceptance, with state still IDLE.
- Edge cases:
  - load_valid held during RUN: not accepted; the new value loads on the edge after done.
  - reset asserted on the same edge as the terminal condition: count=0, done=0, done_cnt=0.
  - 256 completed countdowns: done_cnt wraps to 0.

Source files
------------

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: load handshake, control and status bundle for countdown_timer
// Ports (signals):
//   load_valid/load_ready/load_value : start-value handshake
//   auto_reload, enable, abort       : countdown control
//   count, busy, done, done_cnt      : status
// Modports: master drives load and control inputs; slave is the timer itself.
interface countdown_timer_if #(parameter int COUNT_LEN = 10);
    logic               load_valid;
    logic               load_ready;
    logic [COUNT_LEN:0] load_value;
    logic               auto_reload;
    logic               enable;
    logic               abort;
    logic [COUNT_LEN:0] count;
    logic               busy;
    logic               done;
    logic [7:0]         done_cnt;

    modport master (
        output load_valid, load_value, auto_reload, enable, abort,
        input  load_ready, count, busy, done, done_cnt
    );

    modport slave (
        input  load_valid, load_value, auto_reload, enable, abort,
        output load_ready, count, busy, done, done_cnt
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle done pulse and optional auto-reload
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset
//   bus   : countdown_timer_if.slave (load handshake, control, count/busy/done/done_cnt)
module countdown_timer #(
    parameter int COUNT_LEN = 10
) (
    input logic              clk,
    input logic              reset,
    countdown_timer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [COUNT_LEN:0] ONE = 1;

    state_t             state;
    logic [COUNT_LEN:0] count_q;
    logic [COUNT_LEN:0] reload_reg;
    logic               busy_q;
    logic               done_q;
    logic [7:0]         done_cnt_q;

    assign bus.load_ready = (state == IDLE);
    assign bus.count      = count_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.done_cnt   = done_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count_q    <= '0;
            reload_reg <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.load_valid) begin
                    count_q    <= bus.load_value;
                    reload_reg <= bus.load_value;
                    // A zero start value completes immediately without entering RUN.
                    if (bus.load_value != '0) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end else begin
                        done_q     <= 1'b1;
                        done_cnt_q <= done_cnt_q + 8'd1;
                    end
                end
            end else if (bus.abort) begin
                count_q <= '0;
                state   <= IDLE;
                busy_q  <= 1'b0;
            end else if (bus.enable) begin
                if (count_q == ONE) begin
                    done_q     <= 1'b1;
                    done_cnt_q <= done_cnt_q + 8'd1;
                    // Reload skips the zero display so periodic mode never shows 0.
                    if (bus.auto_reload) begin
                        count_q <= reload_reg;
                    end else begin
                        count_q <= '0;
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end else begin
                    count_q <= count_q - ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and randomized checks of countdown_timer against a behavioural model
module tb_countdown_timer;
    localparam int CL = 10;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    bit m_run;
    bit m_done;
    int m_count;
    int m_reload;
    int m_dcnt;

    countdown_timer_if #(.COUNT_LEN(CL)) bus ();

    countdown_timer #(.COUNT_LEN(CL)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining cycles as an integer, updated from the inputs
    // present before the edge, then the clock advances and outputs settle.
    task automatic tick();
        m_done = 1'b0;
        if (reset) begin
            m_run = 0; m_count = 0; m_reload = 0; m_dcnt = 0;
        end else if (!m_run) begin
            if (bus.load_valid) begin
                m_count  = int'(bus.load_value);
                m_reload = m_count;
                if (m_count == 0) begin
                    m_done = 1'b1;
                    m_dcnt = (m_dcnt + 1) % 256;
                end else begin
                    m_run = 1'b1;
                end
            end
        end else if (bus.abort) begin
            m_run = 1'b0;
            m_count = 0;
        end else if (bus.enable) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_done = 1'b1;
                m_dcnt = (m_dcnt + 1) % 256;
                if (bus.auto_reload) m_count = m_reload;
                else m_run = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_value = '0;
        bus.auto_reload = 1'b0;
        bus.enable = 1'b0;
        bus.abort = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.count !== 11'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.done_cnt !== 8'd0) begin errors++; $display("FAIL reset_done_cnt: got %0d want 0", bus.done_cnt); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", bus.load_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        bus.enable = 1'b1;
        bus.load_value = 11'd5;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            checks++; if (bus.count !== 11'(5 - k)) begin errors++; $display("FAIL basic_count k=%0d: got %0d want %0d", k, bus.count, 5 - k); end
            checks++; if (bus.done !== (k == 5)) begin errors++; $display("FAIL basic_done k=%0d: got %b want %b", k, bus.done, k == 5); end
            checks++; if (bus.busy !== (k != 5)) begin errors++; $display("FAIL basic_busy k=%0d: got %b want %b", k, bus.busy, k != 5); end
        end
        checks++; if (bus.done_cnt !== 8'd1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", bus.done_cnt); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_with_done: got %b want 1", bus.load_ready); end
    endtask

    task automatic test_reload();
        do_reset();
        bus.enable = 1'b1;
        bus.auto_reload = 1'b1;
        bus.load_value = 11'd4;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        checks++; if (bus.count !== 11'd4) begin errors++; $display("FAIL reload_first: got %0d want 4", bus.count); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if (bus.count !== 11'((k % 4 == 0) ? 4 : 4 - k % 4)) begin errors++; $display("FAIL reload_count k=%0d: got %0d", k, bus.count); end
            checks++; if (bus.done !== (k % 4 == 0)) begin errors++; $display("FAIL reload_done k=%0d: got %b want %b", k, bus.done, k % 4 == 0); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reload_busy k=%0d: got %b want 1", k, bus.busy); end
        end
        checks++; if (bus.done_cnt !== 8'd3) begin errors++; $display("FAIL reload_done_cnt: got %0d want 3", bus.done_cnt); end
        bus.auto_reload = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic test_pause();
        int left;
        do_reset();
        bus.enable = 1'b1;
        bus.load_value = 11'd6;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        left = 6;
        for (int k = 1; k <= 9; k++) begin
            bus.enable = !(k >= 4 && k <= 6);
            if (bus.enable) left--;
            tick();
            checks++; if (bus.count !== 11'(left)) begin errors++; $display("FAIL pause_count k=%0d: got %0d want %0d", k, bus.count, left); end
            checks++; if (bus.done !== (k == 9)) begin errors++; $display("FAIL pause_done k=%0d: got %b want %b", k, bus.done, k == 9); end
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_abort();
        do_reset();
        bus.enable = 1'b1;
        bus.load_value = 11'd7;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        repeat (5) tick();
        checks++; if (bus.count !== 11'd2) begin errors++; $display("FAIL abort_pre: got %0d want 2", bus.count); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.enable = 1'b0;
        checks++; if (bus.count !== 11'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", bus.count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.done); end
        checks++; if (bus.done_cnt !== 8'd0) begin errors++; $display("FAIL abort_done_cnt: got %0d want 0", bus.done_cnt); end
        bus.load_value = 11'd0;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", bus.busy); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", bus.load_ready); end
        checks++; if (bus.done_cnt !== 8'd1) begin errors++; $display("FAIL zero_done_cnt: got %0d want 1", bus.done_cnt); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_abort_terminal();
        do_reset();
        bus.enable = 1'b1;
        bus.load_value = 11'd2;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_term_done: got %b want 0", bus.done); end
        checks++; if (bus.count !== 11'd0) begin errors++; $display("FAIL abort_term_count: got %0d want 0", bus.count); end
        checks++; if (bus.done_cnt !== 8'd0) begin errors++; $display("FAIL abort_term_done_cnt: got %0d want 0", bus.done_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.enable = 1'b1;
        bus.load_value = 11'd3;
        bus.load_valid = 1'b1;
        tick();
        bus.load_value = 11'd9;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (bus.count !== 11'(3 - k)) begin errors++; $display("FAIL b2b_count k=%0d: got %0d want %0d", k, bus.count, 3 - k); end
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", bus.done); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.load_ready); end
        tick();
        bus.load_valid = 1'b0;
        checks++; if (bus.count !== 11'd9) begin errors++; $display("FAIL b2b_reload: got %0d want 9", bus.count); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_terminal();
        do_reset();
        bus.enable = 1'b1;
        bus.load_value = 11'd2;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.count !== 11'd0) begin errors++; $display("FAIL rst_term_count: got %0d want 0", bus.count); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_term_done: got %b want 0", bus.done); end
        checks++; if (bus.done_cnt !== 8'd0) begin errors++; $display("FAIL rst_term_done_cnt: got %0d want 0", bus.done_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_term_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.enable = 1'b1;
        bus.load_value = 11'd1;
        bus.load_valid = 1'b1;
        for (int i = 1; i <= 512; i++) begin
            tick();
            if (i == 510) begin
                checks++; if (bus.done_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", bus.done_cnt); end
            end
        end
        bus.load_valid = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", bus.done); end
        checks++; if (bus.done_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", bus.done_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.load_valid  = $urandom_range(0, 2) != 0;
            bus.load_value  = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 9));
            bus.enable      = $urandom_range(0, 3) != 0;
            bus.abort       = $urandom_range(0, 24) == 0;
            bus.auto_reload = $urandom_range(0, 3) == 0;
            reset           = $urandom_range(0, 199) == 0;
            tick();
            checks++; if (bus.count !== 11'(m_count)) begin errors++; $display("FAIL rand_count i=%0d: got %0d want %0d", i, bus.count, m_count); end
            checks++; if (bus.busy !== m_run) begin errors++; $display("FAIL rand_busy i=%0d: got %b want %b", i, bus.busy, m_run); end
            checks++; if (bus.done !== m_done) begin errors++; $display("FAIL rand_done i=%0d: got %b want %b", i, bus.done, m_done); end
            checks++; if (bus.done_cnt !== 8'(m_dcnt)) begin errors++; $display("FAIL rand_done_cnt i=%0d: got %0d want %0d", i, bus.done_cnt, m_dcnt); end
            checks++; if (bus.load_ready !== !m_run) begin errors++; $display("FAIL rand_ready i=%0d: got %b want %b", i, bus.load_ready, !m_run); end
        end
        reset = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        m_run = 0; m_done = 0; m_count = 0; m_reload = 0; m_dcnt = 0;
        test_reset();
        test_basic();
        test_reload();
        test_pause();
        test_abort();
        test_abort_terminal();
        test_back_to_back();
        test_reset_terminal();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
